apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  APB requester: converts a command/response handshake into APB SETUP/ACCESS
//  transfers toward an APB completer (e.g. the 32-word APB RAM).
//  Issues one transfer at a time and returns read data, slave error, or timeout.
//  Sits between the test/CPU-side command source and the APB bus.
// PARAMETERS
//  ADDR_W        32  width of cmd_addr/paddr
//  DATA_W        32  width of write/read data
//  TIMEOUT_CYC   16  max ACCESS cycles with pready=0 before abort (>=2)
// PORTS
//  pclk         in   1       clock, all logic on rising edge
//  preset       in   1       asynchronous reset, active-high
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       bridge accepts command this cycle
//  cmd_write    in   1       1=write, 0=read
//  cmd_addr     in   ADDR_W  target address
//  cmd_wdata    in   DATA_W  write data
//  rsp_valid    out  1       one-cycle pulse: transfer finished
//  rsp_rdata    out  DATA_W  read data (0 for writes/errors/timeouts)
//  rsp_err      out  1       pslverr seen, or timeout
//  rsp_timeout  out  1       transfer aborted by timeout
//  psel         out  1       APB select
//  penable      out  1       APB enable
//  pwrite       out  1       APB direction
//  paddr        out  ADDR_W  APB address
//  pwdata       out  DATA_W  APB write data
//  prdata       in   DATA_W  APB read data
//  pready       in   1       APB completer ready
//  pslverr      in   1       APB completer error
// BEHAVIOUR
//  Reset (async, preset=1): state=IDLE; all outputs 0; timeout counter 0.
//  States: IDLE -> SETUP -> ACCESS -> IDLE.
//  IDLE: cmd_ready=1 (combinational from state). cmd_valid&&cmd_ready at edge:
//   latch cmd_write/addr/wdata into pwrite/paddr/pwdata; psel<=1, penable<=0;
//   go SETUP. No accept in any other state (cmd_ready=0).
//  SETUP: exactly one cycle; penable<=1; counter<=0; go ACCESS.
//  ACCESS: psel=penable=1; paddr/pwrite/pwdata held stable.
//   pready=1 at edge: psel<=0, penable<=0; rsp_valid<=1;
//    rsp_err<=pslverr; rsp_timeout<=0;
//    rsp_rdata<= (!pwrite && !pslverr) ? prdata : 0; go IDLE.
//   pready=0: counter++; when counter reaches TIMEOUT_CYC-1 at edge: abort,
//    psel/penable<=0, rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0;
//    go IDLE. Counter saturates, never wraps.
//  rsp_valid high exactly one cycle (the first IDLE cycle); rsp_rdata/err/
//   timeout hold their value until the next response overwrites them.
//  A new command can be accepted in the same cycle rsp_valid is high;
//   minimum transfer period = 3 cycles (IDLE, SETUP, ACCESS with pready=1).
//  pwrite/paddr/pwdata retain last value in IDLE; psel=0 there.
//  pready/pslverr/prdata ignored outside ACCESS.
//  Illegal state encoding -> IDLE, all bus outputs 0.
//  Reset mid-transfer: immediate abort, psel/penable=0, no rsp_valid.
// TESTING
//  1 write addr=5 data=32'hDEADBEEF, RAM completer -> psel 1 SETUP cycle,
//    penable in ACCESS, rsp_valid pulse, rsp_err=0, rsp_rdata=0.
//  2 read addr=5 after test 1 -> rsp_rdata=32'hDEADBEEF, rsp_err=0.
//  3 read addr=40 (RAM out of range) -> rsp_err=1, rsp_timeout=0, rdata=0.
//  4 pready tied 0, TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles,
//    rsp_err=1, rsp_timeout=1, psel=0 next cycle.
//  5 cmd_valid held high with 4 back-to-back writes addr 0..3 -> 4 rsp pulses,
//    each new accept coincides with prior rsp_valid; memory 0..3 correct.
//  6 preset pulsed during ACCESS -> psel/penable/rsp_valid 0 same cycle,
//    cmd_ready=1 after reset release, next read completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB requester bridge: takes one command at a time, runs it through APB SETUP/ACCESS,
// and reports read data, completer error or timeout on a single-cycle response pulse.
module apb_master_bridge #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // state  | meaning
    // IDLE   | bus idle, command accepted here; first IDLE cycle after a transfer carries rsp_valid
    // SETUP  | psel=1, penable=0, exactly one cycle
    // ACCESS | psel=penable=1, waiting for pready or the wait-state limit
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_access;
    logic             access_done;
    logic             timeout_hit;

    assign cmd_ready   = (state == ST_IDLE);
    assign in_access   = (state == ST_ACCESS);
    assign access_done = in_access && pready;
    // Abort on the last permitted wait cycle so ACCESS lasts exactly TIMEOUT_CYC cycles.
    assign timeout_hit = in_access && !pready && (wait_cnt == CNT_LAST);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (access_done || timeout_hit) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address, direction and write data stay latched after the transfer ends.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        pwrite  <= cmd_write;
                        paddr   <= cmd_addr;
                        pwdata  <= cmd_wdata;
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (access_done || timeout_hit) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    pwrite  <= 1'b0;
                    paddr   <= '0;
                    pwdata  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_SETUP: begin
                    wait_cnt <= '0;
                end
                ST_ACCESS: begin
                    if (!pready && (wait_cnt != CNT_LAST)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    wait_cnt <= wait_cnt;
                end
                default: begin
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (access_done) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
            end else if (timeout_hit) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a 32-word APB RAM completer with programmable wait states,
// and a word-level reference memory predicting each response.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_pass;
    int n_chk;
    int next_wait;
    int wait_left;

    bit [31:0] mem       [32];
    bit [31:0] model_mem [32];

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Completer: addresses >= 32 answer with pslverr; outside ACCESS it drives noise.
    always @(negedge pclk) begin
        if (psel && !penable) wait_left = next_wait;
        if (psel && penable) begin
            if (wait_left == 0) begin
                pready  = 1'b1;
                pslverr = (paddr >= 32'd32);
                if (pslverr || pwrite) prdata = $urandom;
                else prdata = mem[paddr[4:0]];
                if (pwrite && !pslverr) mem[paddr[4:0]] = pwdata;
            end else begin
                wait_left = wait_left - 1;
                pready  = 1'b0;
                pslverr = 1'($urandom_range(0, 1));
                prdata  = $urandom;
            end
        end else begin
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end
    end

    // Issues one command and follows it to its response; all values observed at negedges.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                        output logic [31:0] rd, output logic er, output logic to,
                        output int ns, output int na, output logic stable,
                        output logic busy, output logic dn);
        int n;
        rd = '0; er = 1'b0; to = 1'b0; ns = 0; na = 0; stable = 1'b1; busy = 1'b0; dn = 1'b0;
        next_wait = waits;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge pclk);
            n++;
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        for (int c = 0; c < 200 && !dn; c++) begin
            if (rsp_valid) begin
                dn = 1'b1;
                rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
                busy = psel | penable;
            end else begin
                if (psel && !penable) ns++;
                if (psel && penable) na++;
                if (psel && (paddr !== a || pwrite !== w || pwdata !== d)) stable = 1'b0;
                @(negedge pclk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        n_chk++;
        if ({psel, penable, pwrite, paddr, pwdata} !== '0)
            $display("FAIL reset_bus got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h exp all 0",
                     psel, penable, pwrite, paddr, pwdata);
        else n_pass++;
        n_chk++;
        if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0)
            $display("FAIL reset_rsp got valid=%b rdata=%h err=%b to=%b exp all 0",
                     rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        else n_pass++;
        preset = 1'b0;
        @(negedge pclk);
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [31:0] rd; logic er, to, stb, busy, dn; int ns, na, w;
        w = $urandom_range(0, 3);
        xfer(1'b1, 32'd5, 32'hDEADBEEF, w, rd, er, to, ns, na, stb, busy, dn);
        model_mem[5] = 32'hDEADBEEF;
        n_chk++;
        if (dn !== 1'b1) $display("FAIL write_done got=%b exp=1", dn); else n_pass++;
        n_chk++;
        if (ns != 1) $display("FAIL write_setup_cycles got=%0d exp=1", ns); else n_pass++;
        n_chk++;
        if (na != w + 1) $display("FAIL write_access_cycles got=%0d exp=%0d", na, w + 1); else n_pass++;
        n_chk++;
        if ({er, to, rd} !== 34'd0) $display("FAIL write_rsp got err=%b to=%b rdata=%h exp 0/0/0", er, to, rd);
        else n_pass++;
        n_chk++;
        if (stb !== 1'b1 || busy !== 1'b0)
            $display("FAIL write_bus got stable=%b busy_at_rsp=%b exp 1/0", stb, busy);
        else n_pass++;
        n_chk++;
        if (mem[5] !== 32'hDEADBEEF) $display("FAIL write_mem got=%h exp=%h", mem[5], 32'hDEADBEEF);
        else n_pass++;
        @(negedge pclk);
        n_chk++;
        if (rsp_valid !== 1'b0) $display("FAIL write_pulse_width got rsp_valid=%b exp=0", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_read();
        logic [31:0] rd; logic er, to, stb, busy, dn; int ns, na, w;
        w = $urandom_range(0, 3);
        xfer(1'b0, 32'd5, $urandom, w, rd, er, to, ns, na, stb, busy, dn);
        n_chk++;
        if (dn !== 1'b1 || rd !== model_mem[5] || er !== 1'b0 || to !== 1'b0)
            $display("FAIL read5 got done=%b rdata=%h err=%b to=%b exp 1/%h/0/0", dn, rd, er, to, model_mem[5]);
        else n_pass++;
        n_chk++;
        if (na != w + 1 || ns != 1) $display("FAIL read5_cycles got setup=%0d access=%0d exp 1/%0d", ns, na, w + 1);
        else n_pass++;
        @(negedge pclk);
        n_chk++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== model_mem[5])
            $display("FAIL read5_hold got valid=%b rdata=%h exp 0/%h", rsp_valid, rsp_rdata, model_mem[5]);
        else n_pass++;
    endtask

    task automatic test_slverr();
        logic [31:0] rd; logic er, to, stb, busy, dn; int ns, na, w;
        w = $urandom_range(0, 2);
        xfer(1'b0, 32'd40, $urandom, w, rd, er, to, ns, na, stb, busy, dn);
        n_chk++;
        if (dn !== 1'b1 || er !== 1'b1 || to !== 1'b0 || rd !== 32'd0)
            $display("FAIL slverr_read got done=%b err=%b to=%b rdata=%h exp 1/1/0/0", dn, er, to, rd);
        else n_pass++;
        n_chk++;
        if (na != w + 1) $display("FAIL slverr_access_cycles got=%0d exp=%0d", na, w + 1); else n_pass++;
    endtask

    task automatic test_timeout();
        int wl [3];
        logic [31:0] rd; logic er, to, stb, busy, dn; int ns, na;
        logic exp_to;
        wl[0] = TO - 1; wl[1] = TO; wl[2] = 1000;
        for (int k = 0; k < 3; k++) begin
            xfer(1'b0, 32'd5, $urandom, wl[k], rd, er, to, ns, na, stb, busy, dn);
            exp_to = (wl[k] >= TO);
            n_chk++;
            if (dn !== 1'b1 || na != TO)
                $display("FAIL timeout_cycles waits=%0d got done=%b access=%0d exp 1/%0d", wl[k], dn, na, TO);
            else n_pass++;
            n_chk++;
            if (to !== exp_to || er !== exp_to || rd !== (exp_to ? 32'd0 : model_mem[5]))
                $display("FAIL timeout_rsp waits=%0d got to=%b err=%b rdata=%h exp %b/%b/%h",
                         wl[k], to, er, rd, exp_to, exp_to, exp_to ? 32'd0 : model_mem[5]);
            else n_pass++;
            n_chk++;
            if (busy !== 1'b0) $display("FAIL timeout_bus_release waits=%0d got busy=%b exp=0", wl[k], busy);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bd [4];
        int idx, rsp_cnt, no_overlap, errs;
        logic acc;
        for (int i = 0; i < 4; i++) bd[i] = $urandom;
        next_wait = 0;
        idx = 0; rsp_cnt = 0; no_overlap = 0; errs = 0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd0; cmd_wdata = bd[0];
        for (int c = 0; c < 60 && rsp_cnt < 4; c++) begin
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_err !== 1'b0 || rsp_rdata !== 32'd0) errs++;
            end
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                if (idx > 0 && !rsp_valid) no_overlap++;
                idx++;
            end
            @(negedge pclk);
            if (acc) begin
                if (idx < 4) begin
                    cmd_addr = 32'(idx); cmd_wdata = bd[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) model_mem[i] = bd[i];
        n_chk++;
        if (rsp_cnt != 4 || idx != 4) $display("FAIL b2b_counts got rsp=%0d accepts=%0d exp 4/4", rsp_cnt, idx);
        else n_pass++;
        n_chk++;
        if (no_overlap != 0) $display("FAIL b2b_accept_with_rsp got misses=%0d exp=0", no_overlap);
        else n_pass++;
        n_chk++;
        if (errs != 0) $display("FAIL b2b_rsp_fields got bad=%0d exp=0", errs); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (mem[i] !== bd[i]) $display("FAIL b2b_mem[%0d] got=%h exp=%h", i, mem[i], bd[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp_rd; logic er, to, stb, busy, dn, w, exp_to, exp_er;
        int ns, na, wt, exp_na;
        for (int t = 0; t < 24; t++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 39));
            d  = $urandom;
            wt = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 3);
            exp_to = (wt >= TO);
            exp_er = exp_to || (a >= 32);
            exp_na = exp_to ? TO : wt + 1;
            exp_rd = (!w && !exp_er) ? model_mem[a[4:0]] : 32'd0;
            if (w && !exp_er) model_mem[a[4:0]] = d;
            xfer(w, a, d, wt, rd, er, to, ns, na, stb, busy, dn);
            n_chk++;
            if (dn !== 1'b1 || rd !== exp_rd || er !== exp_er || to !== exp_to)
                $display("FAIL rand[%0d] w=%b a=%0d waits=%0d got done=%b rdata=%h err=%b to=%b exp 1/%h/%b/%b",
                         t, w, a, wt, dn, rd, er, to, exp_rd, exp_er, exp_to);
            else n_pass++;
            n_chk++;
            if (ns != 1 || na != exp_na || stb !== 1'b1)
                $display("FAIL rand_bus[%0d] got setup=%0d access=%0d stable=%b exp 1/%0d/1", t, ns, na, stb, exp_na);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, to, stb, busy, dn; int ns, na, stray;
        next_wait = 1000;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd5; cmd_wdata = $urandom;
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        n_chk++;
        if (psel !== 1'b1 || penable !== 1'b1) $display("FAIL midrst_in_access got psel=%b penable=%b exp 1/1", psel, penable);
        else n_pass++;
        #2 preset = 1'b1;
        #1;
        n_chk++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL midrst_abort got psel=%b penable=%b rsp_valid=%b exp 0/0/0", psel, penable, rsp_valid);
        else n_pass++;
        @(negedge pclk);
        preset = 1'b0;
        #1;
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL midrst_cmd_ready got=%b exp=1", cmd_ready); else n_pass++;
        stray = 0;
        repeat (3) begin
            @(negedge pclk);
            if (rsp_valid !== 1'b0 || psel !== 1'b0) stray++;
        end
        n_chk++;
        if (stray != 0) $display("FAIL midrst_quiet got stray=%0d exp=0", stray); else n_pass++;
        xfer(1'b0, 32'd5, $urandom, 1, rd, er, to, ns, na, stb, busy, dn);
        n_chk++;
        if (dn !== 1'b1 || rd !== model_mem[5] || er !== 1'b0 || to !== 1'b0 || na != 2)
            $display("FAIL midrst_next_read got done=%b rdata=%h err=%b to=%b access=%0d exp 1/%h/0/0/2",
                     dn, rd, er, to, na, model_mem[5]);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_chk = 0;
        next_wait = 0; wait_left = 0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        preset = 1'b0;
        #1 preset = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=timeout exp=finish");
        $fatal(1, "time limit");
    end

endmodule
